// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
package pipe_pkg;

  localparam int PIPE_WIDTH     = 32;
  localparam int PIPE_MAX_DEPTH = 64;

  typedef logic [$clog2(PIPE_MAX_DEPTH)-1:0] stage_idx_t;

  // Bits 0..upto set; an index past the last stage saturates to the last stage.
  function automatic logic [PIPE_MAX_DEPTH-1:0] squash_mask(input int unsigned upto,
                                                            input int unsigned depth);
    int unsigned last;
    logic [PIPE_MAX_DEPTH-1:0] m;
    last = (upto >= depth) ? depth - 1 : upto;
    m = '0;
    for (int unsigned i = 0; i < PIPE_MAX_DEPTH; i++) m[i] = (i <= last);
    return m;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a valid bit plus payload, loaded on load_i, valid cleared on clear_i.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Clear wins over load so a squashed stage never keeps a valid payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain with per-stage backpressure, bubble collapse and partial flush.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH = PIPE_WIDTH,
  parameter  int DEPTH = 4,
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  input  logic [IDXW-1:0]  flush_upto,
  output logic [IDXW:0]    occupancy
);

  logic [DEPTH-1:0] v_q, v_in, v_nxt, rdy, clr;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];
  logic [IDXW:0]    occ_q, occ_d;

  // A stage can accept when it is empty or its successor can accept.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !v_q[i] | r;
      rdy[i] = r;
    end
  end

  assign in_ready = rdy[0] & !flush;
  assign clr      = flush ? DEPTH'(squash_mask(32'(flush_upto), DEPTH)) : '0;

  // A payload leaving a squashed stage arrives downstream as a bubble.
  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid & in_ready;
    d_in[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v_q[i-1] & !clr[i-1];
      d_in[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_nxt = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr[i])      v_nxt[i] = 1'b0;
      else if (rdy[i]) v_nxt[i] = v_in[i];
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + (IDXW+1)'(v_nxt[i]);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (rdy[g]),
      .clear_i (clr[g]),
      .valid_i (v_in[g]),
      .data_i  (d_in[g]),
      .valid_o (v_q[g]),
      .data_o  (d_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: a DEPTH=3 and a DEPTH=4 instance driven with directed vectors.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=3
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_flush = 0;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [1:0]  a_flush_upto = 0;
  logic [2:0]  a_occ;

  // Instance B: DEPTH=4
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_flush = 0;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [1:0]  b_flush_upto = 0;
  logic [2:0]  b_occ;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .flush(a_flush), .flush_upto(a_flush_upto), .occupancy(a_occ));

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .flush(b_flush), .flush_upto(b_flush_upto), .occupancy(b_occ));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] d, input logic r);
    a_in_valid = v; a_in_data = d; a_out_ready = r;
  endtask

  task automatic b_drive(input logic v, input logic [31:0] d, input logic r);
    b_in_valid = v; b_in_data = d; b_out_ready = r;
  endtask

  // Monitor: every output handshake must match the head of the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_out_ready) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL a_out unexpected payload actual=%0h required=none", a_out_data);
        end else begin
          e = qa.pop_front();
          if (a_out_data !== e) begin
            n_fail++;
            $display("FAIL a_out payload actual=%0h required=%0h", a_out_data, e);
          end
        end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL b_out unexpected payload actual=%0h required=none", b_out_data);
        end else begin
          e = qb.pop_front();
          if (b_out_data !== e) begin
            n_fail++;
            $display("FAIL b_out payload actual=%0h required=%0h", b_out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, in_ready=1 while held in reset
    tick(); tick();
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_occ", b_occ, 0);
    rst_n = 1'b1;
    tick();

    // Streaming through DEPTH=3
    qa.push_back(32'h11); qa.push_back(32'h22); qa.push_back(32'h33);
    a_drive(1, 32'h11, 1); tick();
    a_drive(1, 32'h22, 1); tick();
    chk("stream_not_yet_valid", a_out_valid, 0);
    a_drive(1, 32'h33, 1); tick();
    chk("stream_latency_valid", a_out_valid, 1);
    chk("stream_latency_data", a_out_data, 32'h11);
    chk("stream_occ_peak", a_occ, 3);
    a_drive(0, 0, 1);
    tick(); tick(); tick();
    chk("stream_drained_occ", a_occ, 0);

    // Backpressure
    qa.push_back(32'hA); qa.push_back(32'hB); qa.push_back(32'hC); qa.push_back(32'hD);
    a_drive(1, 32'hA, 0); tick();
    a_drive(1, 32'hB, 0); tick();
    a_drive(1, 32'hC, 0); tick();
    chk("bp_occ_full", a_occ, 3);
    chk("bp_out_data_held", a_out_data, 32'hA);
    a_drive(1, 32'hD, 0); #1;
    chk("bp_in_ready_low", a_in_ready, 0);
    tick();
    chk("bp_still_A", a_out_data, 32'hA);
    a_drive(1, 32'hD, 1); #1;
    chk("bp_in_ready_same_cycle", a_in_ready, 1);
    tick();
    chk("bp_occ_stays", a_occ, 3);
    chk("bp_next_out", a_out_data, 32'hB);
    a_drive(0, 0, 1);
    tick(); tick(); tick();
    chk("bp_drained", a_occ, 0);

    // Bubble collapse
    qa.push_back(32'h1); qa.push_back(32'h2);
    a_drive(1, 32'h1, 0); tick();
    a_drive(0, 0, 0);     tick();
    a_drive(1, 32'h2, 0); tick();
    a_drive(0, 0, 0);     tick();
    chk("bubble_occ", a_occ, 2);
    chk("bubble_out_valid", a_out_valid, 1);
    chk("bubble_out_data", a_out_data, 32'h1);
    chk("bubble_in_ready", a_in_ready, 1);
    tick();
    chk("bubble_stable_occ", a_occ, 2);
    a_drive(0, 0, 1);
    tick(); tick(); tick();
    chk("bubble_drained", a_occ, 0);

    // Async reset while full: outputs clear before the next edge
    a_drive(1, 32'h5, 0); tick();
    a_drive(1, 32'h6, 0); tick();
    a_drive(1, 32'h7, 0); tick();
    a_drive(0, 0, 0);
    chk("pre_reset_occ", a_occ, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_occ", a_occ, 0);
    chk("midrst_out_data", a_out_data, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // flush_upto beyond last stage saturates: everything squashed
    a_drive(1, 32'h71, 0); tick();
    a_drive(1, 32'h72, 0); tick();
    a_drive(1, 32'h73, 0); tick();
    a_drive(0, 0, 0);
    a_flush = 1; a_flush_upto = 2'd3; #1;
    chk("clamp_in_ready", a_in_ready, 0);
    tick();
    a_flush = 0; a_flush_upto = 0;
    chk("clamp_occ", a_occ, 0);
    chk("clamp_out_valid", a_out_valid, 0);
    a_drive(0, 0, 1);
    tick(); tick(); tick();

    // Partial flush on DEPTH=4
    qb.push_back(32'h4); qb.push_back(32'h3);
    b_drive(1, 32'h4, 0); tick();
    b_drive(1, 32'h3, 0); tick();
    b_drive(1, 32'h2, 0); tick();
    b_drive(1, 32'h1, 0); tick();
    chk("pflush_full_occ", b_occ, 4);
    b_drive(1, 32'h99, 0);
    b_flush = 1; b_flush_upto = 2'd1; #1;
    chk("pflush_in_ready", b_in_ready, 0);
    tick();
    b_flush = 0; b_flush_upto = 0;
    chk("pflush_occ", b_occ, 2);
    chk("pflush_out_data", b_out_data, 32'h4);
    b_drive(0, 0, 1);
    tick(); tick(); tick(); tick();
    chk("pflush_drained", b_occ, 0);

    // Squashed stage 0 must not propagate into stage 1
    b_drive(1, 32'h50, 1); tick();
    b_drive(0, 0, 1);
    b_flush = 1; b_flush_upto = 2'd0; tick();
    b_flush = 0;
    chk("squash_s0_occ", b_occ, 0);
    tick(); tick(); tick(); tick();

    // Full flush coinciding with an output handshake
    qb.push_back(32'h61);
    b_drive(1, 32'h61, 0); tick();
    b_drive(1, 32'h62, 0); tick();
    b_drive(1, 32'h63, 0); tick();
    b_drive(1, 32'h64, 0); tick();
    b_drive(0, 0, 1);
    b_flush = 1; b_flush_upto = 2'd3; #1;
    chk("fflush_out_valid_before", b_out_valid, 1);
    tick();
    b_flush = 0; b_flush_upto = 0;
    chk("fflush_occ", b_occ, 0);
    chk("fflush_out_valid", b_out_valid, 0);
    tick(); tick(); tick(); tick();

    chk("scoreboard_a_empty", qa.size(), 0);
    chk("scoreboard_b_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
